message_scroller: RTL and testbench

MESSAGE_SCROLLER -- requirements
Module: message_scroller

---
 rtl/message_scroller_pkg.sv | 11 +
 rtl/message_scroller_edge_detect.sv | 21 ++
 rtl/message_scroller.sv | 94 +++++++++
 tb/tb_message_scroller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/message_scroller_pkg.sv
// Shared definitions for the message scroller: FSM encoding and buffer depth.
package message_scroller_pkg;

  localparam int MSG_LEN = 16;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/message_scroller_edge_detect.sv
// Rising-edge detector: registers the input once and flags 0->1 transitions.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/message_scroller.sv
// Scrolls a 16-character hex message across a four-digit LED display,
// either automatically every SCROLL_DIV clocks or one step at a time.
module message_scroller #(
  parameter int SCROLL_DIV = 25000000,
  parameter int MSG_LEN    = message_scroller_pkg::MSG_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         step,
  input  logic                         load_en,
  input  logic [3:0]                   load_addr,
  input  logic [3:0]                   load_data,
  output logic [3:0]                   digit3,
  output logic [3:0]                   digit2,
  output logic [3:0]                   digit1,
  output logic [3:0]                   digit0,
  output logic [3:0]                   window_ptr,
  output logic                         wrap,
  output message_scroller_pkg::state_e fsm_state
);
  import message_scroller_pkg::*;

  localparam int CW = $clog2(SCROLL_DIV);
  localparam logic [CW-1:0] CNT_TERM = CW'(SCROLL_DIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ptr_q, ptr_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    mem_q [MSG_LEN];
  logic [3:0]    digit3_q, digit2_q, digit1_q, digit0_q;
  logic          step_rise;
  logic          terminal;
  logic          advance;

  edge_detect u_step_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (step),
    .rise_o (step_rise)
  );

  // Auto and stepped advances are merged so the pointer moves at most once per clock.
  always_comb begin
    state_d  = run ? ST_RUN : ST_PAUSE;
    terminal = (state_q == ST_RUN) && (cnt_q == CNT_TERM);
    advance  = terminal || ((state_q == ST_PAUSE) && step_rise);
    cnt_d    = '0;
    if ((state_q == ST_RUN) && run && !terminal) begin
      cnt_d = cnt_q + CW'(1);
    end
    ptr_d  = ptr_q + {3'b000, advance};
    wrap_d = advance && (ptr_q == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_PAUSE;
      cnt_q    <= '0;
      ptr_q    <= 4'h0;
      wrap_q   <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) begin
        mem_q[i] <= 4'(i);
      end
      digit3_q <= 4'h0;
      digit2_q <= 4'h1;
      digit1_q <= 4'h2;
      digit0_q <= 4'h3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
      if (load_en) begin
        mem_q[load_addr] <= load_data;
      end
      // Digits follow the current pointer, so they trail window_ptr by one clock.
      digit3_q <= mem_q[ptr_q];
      digit2_q <= mem_q[ptr_q + 4'd1];
      digit1_q <= mem_q[ptr_q + 4'd2];
      digit0_q <= mem_q[ptr_q + 4'd3];
    end
  end

  assign digit3     = digit3_q;
  assign digit2     = digit2_q;
  assign digit1     = digit1_q;
  assign digit0     = digit0_q;
  assign window_ptr = ptr_q;
  assign wrap       = wrap_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller with SCROLL_DIV=4: expected snapshots are
// queued per cycle and a negedge monitor compares them against the outputs.
module tb_message_scroller;
  import message_scroller_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = 4'h0;
  logic [3:0] load_data = 4'h0;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [3:0] window_ptr;
  logic       wrap;
  state_e     fsm_state;

  message_scroller #(.SCROLL_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .digit3     (digit3),
    .digit2     (digit2),
    .digit1     (digit1),
    .digit0     (digit0),
    .window_ptr (window_ptr),
    .wrap       (wrap),
    .fsm_state  (fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: packed {ptr, digit3..digit0, wrap}
  logic [20:0] exp_q[$];
  string       name_q[$];
  int          cyc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  logic [3:0]  mem_m [16];
  int          prev_ptr = 0;

  logic [20:0] mon_exp;
  logic [20:0] mon_act;
  string       mon_name;
  int          mon_cyc;

  always @(negedge clk) begin
    if (cyc_q.size() > 0 && cyc_q[0] == cyc) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_cyc  = cyc_q.pop_front();
      mon_act  = {window_ptr, digit3, digit2, digit1, digit0, wrap};
      n_cmp++;
      if (mon_act !== mon_exp) begin
        n_err++;
        $display("FAIL %s cyc=%0d actual ptr=%h digits=%h wrap=%b required ptr=%h digits=%h wrap=%b",
                 mon_name, mon_cyc, mon_act[20:17], mon_act[16:1], mon_act[0],
                 mon_exp[20:17], mon_exp[16:1], mon_exp[0]);
      end
    end
  end

  // Queue the outputs expected after the coming edge, then advance one clock.
  task automatic cycle(input string nm, input int p, input bit w);
    logic [15:0] dig;
    if (reset) begin
      dig = 16'h0123;
    end else begin
      dig = {mem_m[prev_ptr % 16], mem_m[(prev_ptr + 1) % 16],
             mem_m[(prev_ptr + 2) % 16], mem_m[(prev_ptr + 3) % 16]};
    end
    exp_q.push_back({4'(p), dig, w});
    name_q.push_back(nm);
    cyc_q.push_back(cyc + 1);
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_m[i] = 4'(i);
      prev_ptr = 0;
    end else begin
      if (load_en) mem_m[load_addr] = load_data;
      prev_ptr = p;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = 4'(i);

    // Reset, then stay paused
    cycle("reset", 0, 0);
    cycle("reset", 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cycle("pause_idle", 0, 0);
    n_cmp++;
    if (fsm_state !== ST_PAUSE) begin
      n_err++;
      $display("FAIL pause_state actual state=%0d required state=%0d", fsm_state, ST_PAUSE);
    end

    // Auto scroll: RUN entered on edge 1, advances on edges 5, 9, ... ; wrap on edge 65
    run = 1'b1;
    for (int i = 1; i <= 66; i++) cycle("run_scan", ((i - 1) / 4) % 16, i == 65);
    n_cmp++;
    if (fsm_state !== ST_RUN) begin
      n_err++;
      $display("FAIL run_state actual state=%0d required state=%0d", fsm_state, ST_RUN);
    end
    run = 1'b0;
    cycle("run_stop", 0, 0);
    n_cmp++;
    if (fsm_state !== ST_PAUSE) begin
      n_err++;
      $display("FAIL stop_state actual state=%0d required state=%0d", fsm_state, ST_PAUSE);
    end
    cycle("pause_idle", 0, 0);
    cycle("pause_idle", 0, 0);

    // Held step gives exactly one advance
    step = 1'b1;
    for (int i = 0; i < 5; i++) cycle("step_hold", 1, 0);
    step = 1'b0;
    cycle("step_hold", 1, 0);

    // Three separate pulses from a fresh reset
    reset = 1'b1;
    cycle("reset", 0, 0);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1;
      cycle("step_pulse", k, 0);
      step = 1'b0;
      cycle("step_pulse", k, 0);
    end
    n_cmp++;
    if (window_ptr !== 4'd3) begin
      n_err++;
      $display("FAIL step_pulse_ptr actual ptr=%h required ptr=3", window_ptr);
    end

    // Buffer load at ptr=0: digit1 shows A two edges after the strobe
    reset = 1'b1;
    cycle("reset", 0, 0);
    reset = 1'b0;
    load_en = 1'b1; load_addr = 4'h2; load_data = 4'hA;
    cycle("load", 0, 0);
    load_en = 1'b0;
    cycle("load", 0, 0);

    // Write and step in the same cycle both land
    load_en = 1'b1; load_addr = 4'h4; load_data = 4'hC; step = 1'b1;
    cycle("load_step", 1, 0);
    load_en = 1'b0; step = 1'b0;
    cycle("load_step", 1, 0);

    // Reset two cycles into a RUN count
    run = 1'b1;
    for (int i = 0; i < 3; i++) cycle("mid_run", 1, 0);
    reset = 1'b1;
    cycle("mid_reset", 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle("post_reset", 0, 0);
    cycle("post_reset", 1, 0);

    // Step edge coinciding with terminal count in RUN: single advance
    for (int i = 0; i < 3; i++) cycle("run_step", 1, 0);
    step = 1'b1;
    cycle("run_step", 2, 0);
    step = 1'b0; run = 1'b0;
    cycle("run_step", 2, 0);

    // Step through 15 -> 0 to see the stepped wrap pulse
    for (int k = 0; k <= 13; k++) begin
      step = 1'b1;
      cycle("step_wrap", (3 + k) % 16, ((3 + k) % 16) == 0);
      step = 1'b0;
      cycle("step_wrap", (3 + k) % 16, 1'b0);
    end

    @(posedge clk);
    @(posedge clk);
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_cyc  = cyc_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s cyc=%0d actual unchecked required ptr=%h digits=%h wrap=%b",
               mon_name, mon_cyc, mon_exp[20:17], mon_exp[16:1], mon_exp[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
